pipe_ctrl: RTL and testbench

Pipeline sequencing controller for the five-stage ARM core. It takes load-use hazard, branch-taken and data-memory status signals and drives the freeze and flush controls of the IF, IF/ID, ID/EXE and whole-pipe registers. It owns the memory-wait state machine, so a branch resolved during a memory stall is never lost. It also keeps saturating stall and flush statistics for performance debug.

---
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: memory-wait FSM, branch/hazard arbitration
// for the pipeline register controls, and saturating stall/flush statistics.
module pipe_ctrl #(
    parameter int unsigned BIT_NUMBER  = 32,
    parameter int unsigned MEM_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hazard,
    input  logic                  branch_taken,
    input  logic                  mem_req,
    input  logic                  sram_ready,
    input  logic                  clr_stats,
    output logic                  freeze_pc,
    output logic                  flush_if_id,
    output logic                  flush_id_exe,
    output logic                  freeze_all,
    output logic                  mem_error,
    output logic [BIT_NUMBER-1:0] stall_cnt,
    output logic [BIT_NUMBER-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              pend_br;
    logic [WAIT_W-1:0] wait_cnt;
    logic              flush_eff;
    logic              hazard_stall;

    // State register; reset aborts any memory wait
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and control outputs; everything held at 0 while in reset
    always_comb begin
        state_nxt    = state;
        freeze_all   = 1'b0;
        freeze_pc    = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_exe = 1'b0;
        flush_eff    = 1'b0;
        hazard_stall = 1'b0;
        if (rst) begin
            case (state)
                RUN: begin
                    if (mem_req && !sram_ready) begin
                        state_nxt  = MEM_WAIT;
                        freeze_all = 1'b1;
                    end
                end
                MEM_WAIT: begin
                    if (sram_ready) begin
                        state_nxt = RUN;
                    end else begin
                        freeze_all = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
            // Memory freeze masks everything; a branch (new or deferred) beats a hazard
            if (!freeze_all) begin
                if (branch_taken || pend_br) begin
                    flush_eff    = 1'b1;
                    flush_if_id  = 1'b1;
                    flush_id_exe = 1'b1;
                end else if (hazard) begin
                    hazard_stall = 1'b1;
                    freeze_pc    = 1'b1;
                    flush_id_exe = 1'b1;
                end
            end
        end
    end

    // Remember a branch resolved while frozen until its flush can be applied
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_br <= 1'b0;
        end else if (branch_taken && freeze_all) begin
            pend_br <= 1'b1;
        end else if (flush_eff) begin
            pend_br <= 1'b0;
        end
    end

    // Memory wait watchdog: saturating wait counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt  <= '0;
            mem_error <= 1'b0;
        end else if (state == RUN) begin
            wait_cnt <= '0;
        end else if (!sram_ready && (wait_cnt != WAIT_W'(MEM_TIMEOUT))) begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
            if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
                mem_error <= 1'b1;
            end
        end
    end

    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else if (clr_stats) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze_all || hazard_stall) && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + BIT_NUMBER'(1);
            end
            if (flush_eff && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + BIT_NUMBER'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: vector table plus reset/timeout/saturation sequences.
module tb_pipe_ctrl;

    localparam int unsigned BN = 4;
    localparam int unsigned TO = 4;

    logic          clk;
    logic          rst;
    logic          hazard;
    logic          branch_taken;
    logic          mem_req;
    logic          sram_ready;
    logic          clr_stats;
    logic          freeze_pc;
    logic          flush_if_id;
    logic          flush_id_exe;
    logic          freeze_all;
    logic          mem_error;
    logic [BN-1:0] stall_cnt;
    logic [BN-1:0] flush_cnt;

    int total;
    int bad;

    pipe_ctrl #(.BIT_NUMBER(BN), .MEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .hazard       (hazard),
        .branch_taken (branch_taken),
        .mem_req      (mem_req),
        .sram_ready   (sram_ready),
        .clr_stats    (clr_stats),
        .freeze_pc    (freeze_pc),
        .flush_if_id  (flush_if_id),
        .flush_id_exe (flush_id_exe),
        .freeze_all   (freeze_all),
        .mem_error    (mem_error),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // in = {hazard, branch_taken, mem_req, sram_ready, clr_stats}
    // ctl = {freeze_pc, flush_if_id, flush_id_exe, freeze_all} during the cycle
    // err/st/fl = mem_error, stall_cnt, flush_cnt after the edge
    typedef struct {
        logic [4:0] in;
        logic [3:0] ctl;
        logic       err;
        int         st;
        int         fl;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [4:0] in, input logic [3:0] ctl, input logic err,
                       input int st, input int fl);
        vec_t v;
        v.in  = in;
        v.ctl = ctl;
        v.err = err;
        v.st  = st;
        v.fl  = fl;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] in);
        {hazard, branch_taken, mem_req, sram_ready, clr_stats} = in;
    endtask

    function automatic int ctl_now();
        return int'({freeze_pc, flush_if_id, flush_id_exe, freeze_all});
    endfunction

    // One cycle: inputs already aligned just after a rising edge
    task automatic step(input logic [4:0] in);
        drive(in);
        #4;
        @(posedge clk);
        #1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(5'b10100);

        // Hazard only, then clear
        add(5'b10010, 4'b1010, 1'b0, 1, 0);
        add(5'b10010, 4'b1010, 1'b0, 2, 0);
        add(5'b00000, 4'b0000, 1'b0, 2, 0);
        add(5'b00001, 4'b0000, 1'b0, 0, 0);
        // Branch beats hazard
        add(5'b11010, 4'b0110, 1'b0, 0, 1);
        add(5'b00001, 4'b0000, 1'b0, 0, 0);
        // Memory stall of three frozen cycles, hazard masked while frozen
        add(5'b00100, 4'b0001, 1'b0, 1, 0);
        add(5'b10100, 4'b0001, 1'b0, 2, 0);
        add(5'b00100, 4'b0001, 1'b0, 3, 0);
        add(5'b00010, 4'b0000, 1'b0, 3, 0);
        // Single-cycle access: no freeze
        add(5'b00110, 4'b0000, 1'b0, 3, 0);
        add(5'b00001, 4'b0000, 1'b0, 0, 0);
        // Deferred branch in the second frozen cycle
        add(5'b00100, 4'b0001, 1'b0, 1, 0);
        add(5'b01000, 4'b0001, 1'b0, 2, 0);
        add(5'b00000, 4'b0001, 1'b0, 3, 0);
        add(5'b00010, 4'b0110, 1'b0, 3, 1);
        add(5'b00000, 4'b0000, 1'b0, 3, 1);
        // Two branches while frozen give one flush, which also beats a hazard
        add(5'b00001, 4'b0000, 1'b0, 0, 0);
        add(5'b01100, 4'b0001, 1'b0, 1, 0);
        add(5'b01000, 4'b0001, 1'b0, 2, 0);
        add(5'b10010, 4'b0110, 1'b0, 2, 1);
        add(5'b00000, 4'b0000, 1'b0, 2, 1);

        // Reset state with active-looking inputs: outputs forced low
        #12;
        chk("reset_ctl", ctl_now(), 0);
        chk("reset_err", int'(mem_error), 0);
        chk("reset_stall", int'(stall_cnt), 0);
        chk("reset_flush", int'(flush_cnt), 0);
        drive(5'b00000);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        foreach (vq[i]) begin
            drive(vq[i].in);
            #4;
            chk($sformatf("v%0d_ctl", i), ctl_now(), int'(vq[i].ctl));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_err", i), int'(mem_error), int'(vq[i].err));
            chk($sformatf("v%0d_stall", i), int'(stall_cnt), vq[i].st);
            chk($sformatf("v%0d_flush", i), int'(flush_cnt), vq[i].fl);
        end

        // Saturation of both counters, then clear over increment
        step(5'b00001);
        for (int i = 0; i < 20; i++) begin
            step(5'b10010);
            if (i == 14) chk("stall_reach_max", int'(stall_cnt), 15);
        end
        chk("stall_saturated", int'(stall_cnt), 15);
        for (int i = 0; i < 20; i++) step(5'b01010);
        chk("flush_saturated", int'(flush_cnt), 15);
        step(5'b11011);
        chk("clr_stall", int'(stall_cnt), 0);
        chk("clr_flush", int'(flush_cnt), 0);

        // Timeout: RUN cycle then MEM_WAIT cycles without ready
        step(5'b00100);
        chk("to_enter_err", int'(mem_error), 0);
        for (int i = 1; i <= 5; i++) begin
            drive(5'b00100);
            #4;
            chk($sformatf("to_wait%0d_freeze", i), int'(freeze_all), 1);
            @(posedge clk);
            #1;
            chk($sformatf("to_wait%0d_err", i), int'(mem_error), (i >= 4) ? 1 : 0);
        end
        drive(5'b00010);
        #4;
        chk("to_release_freeze", int'(freeze_all), 0);
        @(posedge clk);
        #1;
        chk("to_sticky_err", int'(mem_error), 1);
        step(5'b00000);
        chk("to_sticky_err2", int'(mem_error), 1);
        chk("to_stall", int'(stall_cnt), 6);

        // Reset in the middle of a wait with a pending branch
        step(5'b01100);
        drive(5'b10100);
        #2;
        chk("rst_pre_freeze", int'(freeze_all), 1);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_async_ctl", ctl_now(), 0);
        chk("rst_async_err", int'(mem_error), 0);
        chk("rst_async_stall", int'(stall_cnt), 0);
        @(posedge clk);
        #3;
        chk("rst_hold_ctl", ctl_now(), 0);
        rst = 1'b1;
        drive(5'b00000);
        #1;
        chk("rst_after_run_no_flush", ctl_now(), 0);
        @(posedge clk);
        #1;
        chk("rst_after_stall", int'(stall_cnt), 0);
        chk("rst_after_flush", int'(flush_cnt), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
